// File: rtl/wb_commit.sv
// wb_commit: writeback/commit stage, drives the register-file write port.
// Ports: MEM-stage handshake in, dmem response in, rf write, load hazard, instret.
module wb_commit #(
  parameter int INSTRET_W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_rd_we,
  input  logic [4:0]           in_rd,
  input  logic                 in_is_load,
  input  logic [2:0]           in_funct3,
  input  logic [2:0]           in_addr_lo,
  input  logic [63:0]          in_alu_res,
  input  logic                 dmem_rvalid,
  input  logic [63:0]          dmem_rdata,
  output logic                 rf_we,
  output logic [4:0]           rf_waddr,
  output logic [63:0]          rf_wdata,
  output logic                 busy_rd_valid,
  output logic [4:0]           busy_rd,
  output logic [INSTRET_W-1:0] instret
);

  typedef enum logic {
    IDLE,
    WAIT_LOAD
  } state_t;

  state_t state_q, state_d;

  logic [4:0] ld_rd_q;
  logic       ld_we_q;
  logic [2:0] ld_f3_q;
  logic [2:0] ld_lo_q;

  logic acc;
  logic ld_done;

  assign in_ready = (state_q == IDLE);
  assign acc      = in_valid & in_ready;
  assign ld_done  = (state_q == WAIT_LOAD) & dmem_rvalid;
  assign busy_rd  = ld_rd_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (acc && in_is_load) state_d = WAIT_LOAD;
      WAIT_LOAD: if (dmem_rvalid) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_w;
  logic [63:0] ld_data;

  assign ld_b = dmem_rdata[{ld_lo_q, 3'b000} +: 8];
  assign ld_h = dmem_rdata[{ld_lo_q[2:1], 4'b0000} +: 16];
  assign ld_w = dmem_rdata[{ld_lo_q[2], 5'b00000} +: 32];

  always_comb begin
    ld_data = dmem_rdata;
    unique case (ld_f3_q)
      3'b000:  ld_data = {{56{ld_b[7]}}, ld_b};
      3'b001:  ld_data = {{48{ld_h[15]}}, ld_h};
      3'b010:  ld_data = {{32{ld_w[31]}}, ld_w};
      3'b100:  ld_data = {56'd0, ld_b};
      3'b101:  ld_data = {48'd0, ld_h};
      3'b110:  ld_data = {32'd0, ld_w};
      default: ld_data = dmem_rdata;
    endcase
  end

  logic        we_d;
  logic [4:0]  waddr_d;
  logic [63:0] wdata_d;
  logic        retire;
  logic        busy_d;
  logic [4:0]  cap_rd;
  logic        cap_we;

  // The pending-load flag is computed for the state being entered,
  // so it rises the cycle after acceptance and drops with the write.
  assign cap_rd = acc ? in_rd : ld_rd_q;
  assign cap_we = acc ? in_rd_we : ld_we_q;

  always_comb begin
    we_d    = 1'b0;
    waddr_d = rf_waddr;
    wdata_d = rf_wdata;
    retire  = 1'b0;
    unique case (1'b1)
      acc && !in_is_load: begin
        we_d    = in_rd_we & (|in_rd);
        waddr_d = in_rd;
        wdata_d = in_alu_res;
        retire  = 1'b1;
      end
      ld_done: begin
        we_d    = ld_we_q & (|ld_rd_q);
        waddr_d = ld_rd_q;
        wdata_d = ld_data;
        retire  = 1'b1;
      end
      default: ;
    endcase
    busy_d = (state_d == WAIT_LOAD) & cap_we & (|cap_rd);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_rd_q <= '0;
      ld_we_q <= 1'b0;
      ld_f3_q <= '0;
      ld_lo_q <= '0;
    end else if (acc && in_is_load) begin
      ld_rd_q <= in_rd;
      ld_we_q <= in_rd_we;
      ld_f3_q <= in_funct3;
      ld_lo_q <= in_addr_lo;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we         <= 1'b0;
      rf_waddr      <= '0;
      rf_wdata      <= '0;
      busy_rd_valid <= 1'b0;
      instret       <= '0;
    end else begin
      rf_we         <= we_d;
      rf_waddr      <= waddr_d;
      rf_wdata      <= wdata_d;
      busy_rd_valid <= busy_d;
      if (retire) instret <= instret + INSTRET_W'(1);
    end
  end

endmodule

// File: tb/tb_wb_commit.sv
// tb_wb_commit: directed and random checks of wb_commit
// against a transaction-level model of commit behaviour.
module tb_wb_commit;

  localparam int IW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          in_rd_we;
  logic [4:0]    in_rd;
  logic          in_is_load;
  logic [2:0]    in_funct3;
  logic [2:0]    in_addr_lo;
  logic [63:0]   in_alu_res;
  logic          dmem_rvalid;
  logic [63:0]   dmem_rdata;
  logic          rf_we;
  logic [4:0]    rf_waddr;
  logic [63:0]   rf_wdata;
  logic          busy_rd_valid;
  logic [4:0]    busy_rd;
  logic [IW-1:0] instret;

  always #5 clk = ~clk;

  wb_commit #(.INSTRET_W(IW)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_rd_we     (in_rd_we),
    .in_rd        (in_rd),
    .in_is_load   (in_is_load),
    .in_funct3    (in_funct3),
    .in_addr_lo   (in_addr_lo),
    .in_alu_res   (in_alu_res),
    .dmem_rvalid  (dmem_rvalid),
    .dmem_rdata   (dmem_rdata),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .busy_rd_valid(busy_rd_valid),
    .busy_rd      (busy_rd),
    .instret      (instret)
  );

  typedef struct {
    logic [4:0] rd;
    logic       we;
    logic [2:0] f3;
    logic [2:0] lo;
  } ld_rec_t;

  ld_rec_t     pend[$];
  int          total = 0;
  int          bad = 0;
  logic        e_we;
  logic [4:0]  e_waddr;
  logic [63:0] e_wdata;
  int          e_cnt;
  logic [4:0]  e_brd;

  function automatic logic [63:0] ext(
    input logic [2:0] f3, input logic [2:0] lo, input logic [63:0] d);
    int sz;
    int off;
    logic [63:0] mask;
    logic [63:0] v;
    sz   = 1 << f3[1:0];
    off  = (int'(lo) / sz) * sz;
    mask = (sz == 8) ? '1 : ((64'd1 << (8 * sz)) - 64'd1);
    v    = (d >> (8 * off)) & mask;
    if (!f3[2] && sz < 8 && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic v, input logic we, input logic [4:0] rd,
                     input logic ld, input logic [2:0] f3,
                     input logic [2:0] lo, input logic [63:0] alu,
                     input logic rv, input logic [63:0] rdata);
    in_valid    = v;
    in_rd_we    = we;
    in_rd       = rd;
    in_is_load  = ld;
    in_funct3   = f3;
    in_addr_lo  = lo;
    in_alu_res  = alu;
    dmem_rvalid = rv;
    dmem_rdata  = rdata;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic step();
    ld_rec_t r;
    @(posedge clk);
    if (rst) begin
      pend.delete();
      e_we = 0; e_waddr = 0; e_wdata = 0; e_cnt = 0; e_brd = 0;
    end else begin
      e_we = 0;
      if (pend.size() == 0) begin
        if (in_valid && in_is_load) begin
          r.rd = in_rd; r.we = in_rd_we; r.f3 = in_funct3; r.lo = in_addr_lo;
          pend.push_back(r);
          e_brd = in_rd;
        end else if (in_valid) begin
          e_we = in_rd_we && in_rd != 0;
          e_waddr = in_rd;
          e_wdata = in_alu_res;
          e_cnt++;
        end
      end else if (dmem_rvalid) begin
        r = pend.pop_front();
        e_we = r.we && r.rd != 0;
        e_waddr = r.rd;
        e_wdata = ext(r.f3, r.lo, dmem_rdata);
        e_cnt++;
      end
    end
    #1;
    chk("in_ready", 64'(in_ready), 64'(pend.size() == 0));
    chk("rf_we", 64'(rf_we), 64'(e_we));
    chk("rf_waddr", 64'(rf_waddr), 64'(e_waddr));
    chk("rf_wdata", rf_wdata, e_wdata);
    chk("busy_v", 64'(busy_rd_valid),
        64'(pend.size() != 0 && pend[0].we && pend[0].rd != 0));
    chk("busy_rd", 64'(busy_rd), 64'(e_brd));
    chk("instret", 64'(instret), 64'(e_cnt % (1 << IW)));
  endtask

  task automatic load_case(input logic [2:0] f3, input logic [2:0] lo,
                           input logic [63:0] d, input logic [63:0] want,
                           input string tag);
    drv(1, 1, 9, 1, f3, lo, 0, 1, d);
    step();
    drv(0, 0, 0, 0, 0, 0, 0, 1, d);
    step();
    chk(tag, rf_wdata, want);
    idle();
  endtask

  initial begin
    rst = 1;
    idle();
    step();
    step();
    chk("rst_instret", 64'(instret), 64'd0);
    rst = 0;

    drv(1, 1, 5, 0, 0, 0, 64'h1234, 0, 0);
    step();
    chk("alu_wdata", rf_wdata, 64'h1234);
    chk("alu_we", 64'(rf_we), 64'd1);
    chk("alu_cnt", 64'(instret), 64'd1);
    idle();
    step();
    chk("alu_we_drop", 64'(rf_we), 64'd0);

    load_case(3'b000, 3, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80, "lb");
    load_case(3'b100, 3, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0080, "lbu");
    load_case(3'b010, 4, 64'h8000_0001_0000_0000, 64'hFFFF_FFFF_8000_0001, "lw");
    load_case(3'b110, 4, 64'h8000_0001_0000_0000, 64'h0000_0000_8000_0001, "lwu");
    load_case(3'b001, 6, 64'h8000_0001_0000_0000, 64'hFFFF_FFFF_FFFF_8000, "lh");
    load_case(3'b111, 5, 64'h8000_0001_0000_0000, 64'h8000_0001_0000_0000, "f3_111");

    drv(1, 1, 0, 0, 0, 0, 64'hDEAD, 0, 0);
    step();
    chk("rd0_we", 64'(rf_we), 64'd0);
    idle();
    step();

    rst = 1;
    step();
    rst = 0;
    drv(1, 1, 7, 1, 3'b011, 0, 0, 0, 0);
    step();
    drv(1, 1, 8, 0, 0, 0, 64'h88, 0, 64'h77);
    step();
    chk("hold_busy_rd", 64'(busy_rd), 64'd7);
    chk("hold_ready", 64'(in_ready), 64'd0);
    step();
    drv(1, 1, 8, 0, 0, 0, 64'h88, 1, 64'h77);
    step();
    chk("ld7_addr", 64'(rf_waddr), 64'd7);
    chk("ld7_data", rf_wdata, 64'h77);
    chk("ld7_ready", 64'(in_ready), 64'd1);
    drv(1, 1, 8, 0, 0, 0, 64'h88, 0, 0);
    step();
    chk("rd8_addr", 64'(rf_waddr), 64'd8);
    chk("two_retired", 64'(instret), 64'd2);
    idle();
    step();

    rst = 1;
    step();
    rst = 0;
    drv(1, 1, 3, 1, 0, 0, 0, 0, 0);
    step();
    rst = 1;
    idle();
    step();
    rst = 0;
    drv(0, 0, 0, 0, 0, 0, 0, 1, 64'h55);
    step();
    chk("abandon_we", 64'(rf_we), 64'd0);
    chk("abandon_cnt", 64'(instret), 64'd0);
    chk("abandon_busy", 64'(busy_rd_valid), 64'd0);
    idle();

    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 79) == 0);
      drv($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
          5'($urandom_range(0, 31)), $urandom_range(0, 1) != 0,
          3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
          {$urandom, $urandom}, $urandom_range(0, 2) == 0,
          {$urandom, $urandom});
      step();
    end
    rst = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_commit.md
Name: wb_commit

Overview:
- Writeback/commit stage for the 64-bit RV pipeline: the writer side of the register file write port.
- Accepts completed instructions from the MEM stage over a valid/ready handshake.
- For loads, waits for the data-memory response, then aligns and extends the data.
- Drives registered rf_we/rf_waddr/rf_wdata into the register file, and maintains the retired-instruction counter plus a pending-load hazard indication for decode.

Parameters:
- INSTRET_W, 64, width of the retired-instruction counter (wraps modulo 2^INSTRET_W).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  MEM-stage record valid.
- in_ready  output  1  stage can accept a record this cycle.
- in_rd_we  input  1  instruction writes rd.
- in_rd  input  5  destination register.
- in_is_load  input  1  record is a load; data comes from dmem.
- in_funct3  input  3  load type: 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu.
- in_addr_lo  input  3  load effective address bits [2:0].
- in_alu_res  input  64  result for non-load records.
- dmem_rvalid  input  1  load data valid (single-cycle pulse).
- dmem_rdata  input  64  aligned 64-bit doubleword containing the load target.
- rf_we  output  1  register-file write enable (one-cycle pulse).
- rf_waddr  output  5  write address.
- rf_wdata  output  64  write data.
- busy_rd_valid  output  1  a load is pending and will write busy_rd.
- busy_rd  output  5  destination of the pending load.
- instret  output  INSTRET_W  retired-instruction count.

Behaviour:
- Reset state: IDLE. Every registered output is 0: rf_we, rf_waddr, rf_wdata, busy_rd_valid, busy_rd, instret. Reset is synchronous and overrides all other inputs in that cycle.
- State machine: IDLE, WAIT_LOAD.
- in_ready is combinational and equals (state == IDLE). It is 0 throughout WAIT_LOAD.
- A record is accepted when in_valid & in_ready.
- IDLE, accepted non-load:
  - On the next cycle: rf_we = in_rd_we & (in_rd != 0), rf_waddr = in_rd, rf_wdata = in_alu_res, instret += 1.
  - State stays IDLE, so back-to-back records retire one per cycle.
- IDLE, accepted load:
  - Capture rd, rd_we, funct3 and addr_lo; go to WAIT_LOAD.
  - rf_we = 0 on the next cycle.
- WAIT_LOAD, dmem_rvalid = 1:
  - On the next cycle: rf_we = captured_rd_we & (rd != 0), rf_waddr = rd, rf_wdata = extracted data, instret += 1.
  - State returns to IDLE, so in_ready is high in that same next cycle.
- WAIT_LOAD, no dmem_rvalid: hold; no timeout.
- Load data extraction from dmem_rdata:
  - byte = rdata[8*addr_lo +: 8].
  - half = rdata[16*addr_lo[2:1] +: 16].
  - word = rdata[32*addr_lo[2] +: 32].
  - ld returns rdata unchanged.
  - lb/lh/lw sign-extend to 64 bits; lbu/lhu/lwu zero-extend.
  - Address bits below the access size are ignored; alignment is the issuer's responsibility.
  - funct3 111 is treated as ld.
- rf_we is never high for more than one cycle per record. When rf_we = 0, rf_waddr/rf_wdata still update to the record's values, but the register file ignores them.
- Writes to rd = 0 are suppressed, but the instruction still retires (instret increments).
- busy_rd_valid = (state == WAIT_LOAD) & captured_rd_we & (rd != 0). It is registered, high from the cycle after load acceptance through the cycle dmem_rvalid is seen. busy_rd holds the captured rd.
- Boundary cases:
  - dmem_rvalid while in IDLE, including the acceptance cycle of a load, is ignored: no write, no count. A response must arrive at least one cycle after acceptance.
  - Reset during WAIT_LOAD abandons the load: no write, and a later dmem_rvalid is ignored.
  - instret wraps from all-ones to 0.

Test Plan:
- ALU record: rd=5, alu_res=0x1234, rd_we=1 → next cycle rf_we=1, waddr=5, wdata=0x1234, instret=1; the following cycle rf_we=0.
- lb with addr_lo=3, rdata=0x0000_0000_8000_0000, 1-cycle latency → rf_wdata=0xFFFF_FFFF_FFFF_FF80. The same with lbu → 0x0000_0000_0000_0080.
- lw with addr_lo=4, rdata=0x8000_0001_0000_0000 → 0xFFFF_FFFF_8000_0001. lwu → 0x0000_0000_8000_0001. lh with addr_lo=6 → 0xFFFF_FFFF_FFFF_8000.
- ALU record with rd=0 and alu_res=0xDEAD → rf_we stays 0; instret increments by 1.
- Load to rd=7, dmem_rvalid 3 cycles after acceptance, with an ALU record to rd=8 held on in_valid → in_ready=0 and busy_rd_valid=1/busy_rd=7 during the wait. The rd=7 write occurs the cycle after rvalid; the rd=8 record is accepted that same cycle and written on the cycle after; instret ends at 2.
- Load accepted, rst pulsed for 1 cycle in WAIT_LOAD, then dmem_rvalid=1 → no rf_we, instret=0, in_ready=1, busy_rd_valid=0.
